instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 110 +++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, issues single-cycle instruction memory
// requests and fills the IF/ID register. A one-entry hold buffer absorbs a
// fetch that completes while decode is stalled, so nothing is dropped.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic [31:0] i_imem_rdata,
  output logic        o_valid,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  output logic [31:0] o_fetch_count
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc;
  logic        accept;

  assign pc_plus4 = pc + 32'd4;
  // Redirect wins over a ready memory in the same cycle.
  assign accept   = o_imem_req & i_imem_ready & ~i_redirect;

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state: redirect always restarts fetching; HOLD waits for decode
  always_comb begin
    state_nxt = state;
    if (i_redirect) begin
      state_nxt = FETCH;
    end else begin
      case (state)
        IDLE:    state_nxt = FETCH;
        FETCH:   if (accept && i_stall && o_valid) state_nxt = HOLD;
        HOLD:    if (!i_stall) state_nxt = FETCH;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Memory request only while fetching; the address is simply the PC
  always_comb begin
    o_imem_req  = (state == FETCH);
    o_imem_addr = pc;
  end

  // PC, IF/ID register, hold buffer and fetch counter
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pc            <= RESET_PC;
      o_valid       <= 1'b0;
      o_instruction <= '0;
      o_pc          <= '0;
      o_pc_plus4    <= '0;
      o_fetch_count <= '0;
      hold_instr    <= '0;
      hold_pc       <= '0;
    end else if (i_redirect) begin
      // Leaving HOLD via redirect implicitly discards the buffer.
      pc      <= {i_redirect_pc[31:2], 2'b00};
      o_valid <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (accept) begin
            pc            <= pc_plus4;
            o_fetch_count <= o_fetch_count + 32'd1;
            if (i_stall && o_valid) begin
              hold_instr <= i_imem_rdata;
              hold_pc    <= pc;
            end else begin
              o_valid       <= 1'b1;
              o_instruction <= i_imem_rdata;
              o_pc          <= pc;
              o_pc_plus4    <= pc_plus4;
            end
          end else if (!i_stall) begin
            o_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!i_stall) begin
            o_valid       <= 1'b1;
            o_instruction <= hold_instr;
            o_pc          <= hold_pc;
            o_pc_plus4    <= hold_pc + 32'd4;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
